// File: rtl/btn_start_pulse_pkg.sv
// Shared types and default constants for the pushbutton start-pulse generator.
package btn_start_pulse_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
    localparam int unsigned SYNC_STAGES_DEF     = 2;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/btn_start_pulse_sync_ff.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_ff
    import btn_start_pulse_pkg::*;
#(
    parameter int unsigned DEPTH = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] chain;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[DEPTH-2:0], d};
        end
    end

    assign q = chain[DEPTH-1];

endmodule

// File: rtl/btn_start_pulse.sv
// Debounces a raw pushbutton and emits one start pulse per qualified press.
module btn_start_pulse
    import btn_start_pulse_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic start,
    output logic btn_level,
    output logic busy
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_sync;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             start_nxt;
    logic             level_nxt;
    logic             busy_nxt;

    sync_ff #(
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (btn_sync)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            start     <= 1'b0;
            btn_level <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            start     <= start_nxt;
            btn_level <= level_nxt;
            busy      <= busy_nxt;
        end
    end

    // Counter defaults to 0 so it is cleared on every entry and idles at 0.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        case (state)
            IDLE: begin
                if (btn_sync) state_nxt = DB_PRESS;
            end
            DB_PRESS: begin
                if (!btn_sync)             state_nxt = IDLE;
                else if (cnt == CNT_LAST)  state_nxt = HELD;
                else                       cnt_nxt   = cnt + CNT_W'(1);
            end
            HELD: begin
                if (!btn_sync) state_nxt = DB_RELEASE;
            end
            DB_RELEASE: begin
                if (btn_sync)              state_nxt = HELD;
                else if (cnt == CNT_LAST)  state_nxt = IDLE;
                else                       cnt_nxt   = cnt + CNT_W'(1);
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Only a completed press qualification fires start; re-entry from a release bounce does not.
        start_nxt = (state == DB_PRESS) && (state_nxt == HELD);
        level_nxt = (state_nxt == HELD) || (state_nxt == DB_RELEASE);
        busy_nxt  = (state_nxt != IDLE);
    end

endmodule
